// File: rtl/rr_control_sequencer.sv
// Hardwired fetch/execute sequencer for three-register ALU instructions.
// Every output is decoded from the state register (plus IR fields) and is stable for the whole cycle.
module rr_control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             mem_rdy,
  input  logic [31:0]      IR_Data,
  output logic             PC_out,
  output logic             MAR_in,
  output logic             IncPC,
  output logic             Z_in,
  output logic             Zlow_out,
  output logic             PC_in,
  output logic             Read,
  output logic             MDR_in,
  output logic             MDR_out,
  output logic             IR_in,
  output logic             Y_in,
  output logic [NREGS-1:0] R_out,
  output logic [NREGS-1:0] R_in,
  output logic [OPW-1:0]   alu_instruction,
  output logic             halted,
  output logic             illegal,
  output logic [CNTW-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  localparam logic [NREGS-1:0] ONE    = NREGS'(1);
  localparam logic [4:0]       OP_NOP = 5'h1A;
  localparam logic [4:0]       OP_HLT = 5'h1F;

  state_t            r_state, w_next;
  logic              r_t1_wait;
  logic [CNTW-1:0]   r_count;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_is_alu, w_is_nop, w_is_hlt;
  logic       w_unused;

  assign w_op     = IR_Data[31:27];
  assign w_ra     = IR_Data[26:23];
  assign w_rb     = IR_Data[22:19];
  assign w_rc     = IR_Data[18:15];
  assign w_unused = ^IR_Data[14:0];
  assign w_is_alu = (w_op <= 5'h0C);
  assign w_is_nop = (w_op == OP_NOP);
  assign w_is_hlt = (w_op == OP_HLT);

  // r_t1_wait marks repeated T1 cycles so the PC reload happens only on the first one.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_t1_wait <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next;
      r_t1_wait <= (r_state == S_T1) && !mem_rdy;
      if (r_state == S_T5) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run) w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    if (mem_rdy) w_next = S_T2;
      S_T2:    w_next = S_T3;
      S_T3: begin
        if (w_is_alu)      w_next = S_T4;
        else if (w_is_hlt) w_next = S_HALT;
        else               w_next = run ? S_T0 : S_IDLE;
      end
      S_T4:    w_next = S_T5;
      S_T5:    w_next = run ? S_T0 : S_IDLE;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    PC_out = 1'b0; MAR_in = 1'b0; IncPC = 1'b0; Z_in = 1'b0;
    Zlow_out = 1'b0; PC_in = 1'b0; Read = 1'b0; MDR_in = 1'b0;
    MDR_out = 1'b0; IR_in = 1'b0; Y_in = 1'b0;
    R_out = '0; R_in = '0; alu_instruction = '0;
    halted = 1'b0; illegal = 1'b0;
    case (r_state)
      S_T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
      end
      S_T1: begin
        Read = 1'b1; MDR_in = 1'b1;
        Zlow_out = !r_t1_wait; PC_in = !r_t1_wait;
      end
      S_T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
      end
      S_T3: begin
        if (w_is_alu) begin
          R_out = ONE << w_rb; Y_in = 1'b1;
        end else if (!w_is_nop && !w_is_hlt) begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        R_out = ONE << w_rc; alu_instruction = OPW'(w_op); Z_in = 1'b1;
      end
      S_T5: begin
        Zlow_out = 1'b1; R_in = ONE << w_ra;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = r_count;

endmodule
